mustang_fast_top: RTL and testbench
===================================

Name: mustang_fast_top

Overview:
- Compact board-level I/O shell for the Mustang_fast FPGA build.
- A UART debug command port at address DEBUG_ADDR reads and writes a small register file.
- The registers drive the two GPIO ports, a PWM output, the debug LED and the JTAG-header GPIOs.
- All other board interfaces (SPI SRAM, Si3000 codec, SD card, I2C, aux UART) are held at safe idle levels.

Parameters:
- CLK_HZ, 12000000, oscillator frequency in Hz.
- BAUD, 115200, UART bit rate. Divisor = round(CLK_HZ/BAUD) = 104 clocks per bit.
- DEBUG_ADDR, 8'hC0, frame address byte that opens a command.

Ports:
- osc_in  in  1  system clock (12 MHz).
- push_button  in  1  reset; synchronous, active-high.
- INTx  in  2  external interrupt lines; 2-FF synchronised, readable only.
- P0, P1  out  8 each  GPIO ports.
- UART_RXD  in  1  debug UART receive.
- UART_TXD  out  1  debug UART transmit.
- UART_AUX_RXD  in  1  unused.
- UART_AUX_TXD  out  1  constant 1.
- debug_led  out  1  LED register bit 0.
- mem_so  in  1  unused.
- mem_si, mem_sck  out  1 each  constant 0.
- mem_hold_n, mem_cs_n  out  1 each  constant 1.
- Si3000_SDI, Si3000_SCLK, Si3000_MCLK, Si3000_RESET_N  out  1 each  constant 0; codec held in reset.
- Si3000_SDO  out  1  constant 0.
- Si3000_FSYNC_N  in  1  unused.
- SD_SPI_CS, SD_DAT2, SD_DAT1  out  1 each  constant 1.
- SD_SPI_CLK, SD_SPI_DI  out  1 each  constant 0.
- SD_SPI_DO  in  1  unused.
- I2C_SDA, I2C_SCL  out  1 each  constant 1 (bus released).
- PWM_OUT  out  1  PWM output.
- JTAG_PIN6, JTAG_PIN7, JTAG_PIN8  out  1 each  JTAG register bits 0, 1, 2.

Behaviour:
- Clock and reset: all flops are clocked on rising osc_in. push_button=1 at a clock edge resets every register.
- Reset values:
  - P0 = P1 = 8'hFF.
  - PWM duty = 0, so PWM_OUT = 0.
  - debug_led = 0, JTAG pins = 0.
  - UART_TXD = 1; RX/TX/parser return to IDLE.
  - Reset mid-frame or mid-transmission aborts it immediately.
- UART RX (8N1, LSB first):
  - UART_RXD passes through a 2-FF synchroniser.
  - A falling edge starts reception. Start bit is re-checked at half-bit (52 clocks); if high, the start is treated as a glitch and RX returns to idle.
  - Data bits are sampled every 104 clocks at mid-bit.
  - Stop bit = 0 is a framing error: the byte is discarded.
  - A valid byte raises a 1-cycle rx_valid at the stop-bit sample.
- UART TX (8N1, LSB first): start bit, 8 data bits, stop bit, 104 clocks each. TX is busy until the stop bit completes.
- Parser states are IDLE, GOT_ADDR, GOT_REG.
  - IDLE: a byte equal to DEBUG_ADDR moves to GOT_ADDR; any other byte is ignored.
  - GOT_ADDR, byte bit7 = 0: store the register index and move to GOT_REG.
  - GOT_ADDR, byte bit7 = 1: read request for index byte[6:0]; return to IDLE.
  - GOT_REG: the byte is write data. Write the register on the cycle after rx_valid, then return to IDLE.
  - No inter-byte timeout.
- Register map:
  - 0: P0.
  - 1: P1.
  - 2: PWM duty.
  - 3: debug_led, bit 0 only.
  - 4: JTAG pins, bits[2:0].
  - 5: read-only {6'b0, INTx_sync}.
- Write rules:
  - Writes to index 5 or >5 are ignored.
  - Unused bits read back as 0.
- Read rules:
  - A read returns the register value as one TX byte.
  - TX start bit begins no later than 2 clocks after the rx_valid of the request byte.
  - Unmapped indices return 8'h00.
  - A read request while TX is busy is dropped.
- PWM:
  - A free-running 8-bit counter increments every clock and wraps 255 to 0.
  - PWM_OUT is registered and equals (counter < duty).
  - duty = 0 gives constant 0; duty = 255 gives high for 255 of every 256 clocks.
  - A duty change takes effect on the next counter compare.
- Outputs are registered or constant; no combinational path from inputs to outputs.

Test Plan:
- Hold push_button = 1 for 30 clocks, then release.
  - Required: P0 = P1 = FF, PWM_OUT = 0, debug_led = 0, UART_TXD = 1, mem_cs_n = 1, SD_SPI_CS = 1, I2C lines = 1, all for 10+ clocks.
- Send bytes C0,00,5A then C0,01,A5 at 115200 baud.
  - Required: P0 = 5A and P1 = A5, each within 2 clocks after the third byte's stop sample.
- Send C0,02,40.
  - Required: PWM_OUT high exactly 64 of every 256 clocks.
- Send C0,02,00.
  - Required: PWM_OUT constantly 0.
- Send C0,03,01 then C0,83.
  - Required: debug_led = 1; UART_TXD returns byte 01.
- Send C0,85 with INTx = 2'b10 held.
  - Required: reply 02.
- Send C0,86.
  - Required: reply 00.
- Send C1,00,33.
  - Required: P0 unchanged.
- Framing-error byte followed by C0,04,07.
  - Required: JTAG pins 6/7/8 = 1.
- Assert reset mid-frame, then send 00,12.
  - Required: no register write occurs.

Source files
------------

// File: rtl/mustang_fast_top_if.sv
// Debug UART link of the Mustang_fast shell: the host side drives RXD and
// listens on TXD.
interface mustang_fast_top_if;
    logic UART_RXD;
    logic UART_TXD;

    modport master (output UART_RXD, input UART_TXD);
    modport slave  (input UART_RXD, output UART_TXD);
endinterface

// File: rtl/mustang_fast_top.sv
// Mustang_fast board shell: UART debug command port driving a small register
// file (GPIO, PWM duty, LED, JTAG-header pins); all other interfaces idle.
module mustang_fast_top #(
    parameter int          CLK_HZ     = 12000000,
    parameter int          BAUD       = 115200,
    parameter logic [7:0]  DEBUG_ADDR = 8'hC0
) (
    input  logic       osc_in,
    input  logic       push_button,
    input  logic [1:0] INTx,
    output logic [7:0] P0,
    output logic [7:0] P1,
    mustang_fast_top_if.slave dbg,
    input  logic       UART_AUX_RXD,
    output logic       UART_AUX_TXD,
    output logic       debug_led,
    input  logic       mem_so,
    output logic       mem_si,
    output logic       mem_sck,
    output logic       mem_hold_n,
    output logic       mem_cs_n,
    output logic       Si3000_SDI,
    output logic       Si3000_SCLK,
    output logic       Si3000_MCLK,
    output logic       Si3000_RESET_N,
    output logic       Si3000_SDO,
    input  logic       Si3000_FSYNC_N,
    output logic       SD_SPI_CS,
    output logic       SD_DAT2,
    output logic       SD_DAT1,
    output logic       SD_SPI_CLK,
    output logic       SD_SPI_DI,
    input  logic       SD_SPI_DO,
    output logic       I2C_SDA,
    output logic       I2C_SCL,
    output logic       PWM_OUT,
    output logic       JTAG_PIN6,
    output logic       JTAG_PIN7,
    output logic       JTAG_PIN8
);
    localparam int          DIV       = (CLK_HZ + BAUD / 2) / BAUD;
    localparam logic [15:0] BIT_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_GOT_ADDR, P_GOT_REG} p_state_t;

    logic clk, srst;
    assign clk  = osc_in;
    assign srst = push_button;

    logic unused_inputs;
    assign unused_inputs = ^{UART_AUX_RXD, mem_so, Si3000_FSYNC_N, SD_SPI_DO};

    // ---------------- input synchronisers ----------------
    logic [1:0] rxd_sync_reg;
    logic       rxd_prev_reg;
    logic [1:0] intx_meta_reg, intx_sync_reg;
    logic       rxd_s;
    assign rxd_s = rxd_sync_reg[1];

    always_ff @(posedge clk) begin
        if (srst) begin
            rxd_sync_reg <= 2'b11;
            rxd_prev_reg <= 1'b1;
        end else begin
            rxd_sync_reg <= {rxd_sync_reg[0], dbg.UART_RXD};
            rxd_prev_reg <= rxd_s;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_intx_sync
            always_ff @(posedge clk) begin
                if (srst) begin
                    intx_meta_reg[gi] <= 1'b0;
                    intx_sync_reg[gi] <= 1'b0;
                end else begin
                    intx_meta_reg[gi] <= INTx[gi];
                    intx_sync_reg[gi] <= intx_meta_reg[gi];
                end
            end
        end
    endgenerate

    // ---------------- UART receiver ----------------
    rx_state_t   rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic        rx_valid_reg, rx_valid_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + 16'd1;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_valid_next = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rxd_prev_reg && !rxd_s)
                    rx_state_next = RX_START;
            end
            RX_START: begin
                // A start bit that is already high again at half-bit was a glitch.
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rxd_s, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7)
                        rx_state_next = RX_STOP;
                end
            end
            default: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_state_next = RX_IDLE;
                    rx_valid_next = rxd_s;
                end
            end
        endcase
    end

    // ---------------- register file ----------------
    logic [7:0] p0_reg, p1_reg, duty_reg;
    logic       led_reg;
    logic [2:0] jtag_reg;
    logic       wr_en_reg, wr_en_next;
    logic [6:0] wr_idx_reg, wr_idx_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic [7:0] rd_data;

    always_ff @(posedge clk) begin
        if (srst) begin
            p0_reg   <= 8'hFF;
            p1_reg   <= 8'hFF;
            duty_reg <= 8'h00;
            led_reg  <= 1'b0;
            jtag_reg <= 3'b000;
        end else if (wr_en_reg) begin
            case (wr_idx_reg)
                7'd0:    p0_reg   <= wr_data_reg;
                7'd1:    p1_reg   <= wr_data_reg;
                7'd2:    duty_reg <= wr_data_reg;
                7'd3:    led_reg  <= wr_data_reg[0];
                7'd4:    jtag_reg <= wr_data_reg[2:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        case (rx_shift_reg[6:0])
            7'd0:    rd_data = p0_reg;
            7'd1:    rd_data = p1_reg;
            7'd2:    rd_data = duty_reg;
            7'd3:    rd_data = {7'b0, led_reg};
            7'd4:    rd_data = {5'b0, jtag_reg};
            7'd5:    rd_data = {6'b0, intx_sync_reg};
            default: rd_data = 8'h00;
        endcase
    end

    // ---------------- command parser ----------------
    p_state_t   p_state_reg, p_state_next;
    logic [6:0] reg_idx_reg, reg_idx_next;
    logic       tx_start, tx_busy;

    always_ff @(posedge clk) begin
        if (srst) begin
            p_state_reg <= P_IDLE;
            reg_idx_reg <= '0;
            wr_en_reg   <= 1'b0;
            wr_idx_reg  <= '0;
            wr_data_reg <= '0;
        end else begin
            p_state_reg <= p_state_next;
            reg_idx_reg <= reg_idx_next;
            wr_en_reg   <= wr_en_next;
            wr_idx_reg  <= wr_idx_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        p_state_next = p_state_reg;
        reg_idx_next = reg_idx_reg;
        wr_en_next   = 1'b0;
        wr_idx_next  = wr_idx_reg;
        wr_data_next = wr_data_reg;
        tx_start     = 1'b0;
        if (rx_valid_reg) begin
            case (p_state_reg)
                P_IDLE: begin
                    if (rx_shift_reg == DEBUG_ADDR)
                        p_state_next = P_GOT_ADDR;
                end
                P_GOT_ADDR: begin
                    if (rx_shift_reg[7]) begin
                        tx_start     = !tx_busy;   // dropped while a reply is going out
                        p_state_next = P_IDLE;
                    end else begin
                        reg_idx_next = rx_shift_reg[6:0];
                        p_state_next = P_GOT_REG;
                    end
                end
                default: begin
                    wr_en_next   = 1'b1;
                    wr_idx_next  = reg_idx_reg;
                    wr_data_next = rx_shift_reg;
                    p_state_next = P_IDLE;
                end
            endcase
        end
    end

    // ---------------- UART transmitter ----------------
    tx_state_t   tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic        txd_reg, txd_next;

    assign tx_busy = (tx_state_reg != TX_IDLE);

    always_ff @(posedge clk) begin
        if (srst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= txd_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg + 16'd1;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        txd_next      = txd_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_cnt_next = '0;
                txd_next    = 1'b1;
                if (tx_start) begin
                    tx_state_next = TX_START;
                    tx_shift_next = rd_data;
                    txd_next      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    txd_next      = tx_shift_reg[0];
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 3'd7) begin
                        txd_next      = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        txd_next      = tx_shift_reg[1];
                    end
                end
            end
            default: begin
                if (tx_cnt_reg == BIT_LAST)
                    tx_state_next = TX_IDLE;
            end
        endcase
    end

    // ---------------- PWM ----------------
    logic [7:0] pwm_cnt_reg;
    logic       pwm_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pwm_cnt_reg <= 8'h00;
            pwm_reg     <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            pwm_reg     <= (pwm_cnt_reg < duty_reg);
        end
    end

    // ---------------- outputs ----------------
    assign P0             = p0_reg;
    assign P1             = p1_reg;
    assign dbg.UART_TXD   = txd_reg;
    assign debug_led      = led_reg;
    assign PWM_OUT        = pwm_reg;
    assign JTAG_PIN6      = jtag_reg[0];
    assign JTAG_PIN7      = jtag_reg[1];
    assign JTAG_PIN8      = jtag_reg[2];
    assign UART_AUX_TXD   = 1'b1;
    assign mem_si         = 1'b0;
    assign mem_sck        = 1'b0;
    assign mem_hold_n     = 1'b1;
    assign mem_cs_n       = 1'b1;
    assign Si3000_SDI     = 1'b0;
    assign Si3000_SCLK    = 1'b0;
    assign Si3000_MCLK    = 1'b0;
    assign Si3000_RESET_N = 1'b0;
    assign Si3000_SDO     = 1'b0;
    assign SD_SPI_CS      = 1'b1;
    assign SD_DAT2        = 1'b1;
    assign SD_DAT1        = 1'b1;
    assign SD_SPI_CLK     = 1'b0;
    assign SD_SPI_DI      = 1'b0;
    assign I2C_SDA        = 1'b1;
    assign I2C_SCL        = 1'b1;
endmodule

// File: tb/tb_mustang_fast_top.sv
// Command-table bench for mustang_fast_top: UART commands in, register/PWM
// outputs checked per command, read replies checked from a scoreboard queue.
module tb_mustang_fast_top;
    localparam int BIT_CLKS = 104;

    logic       clk;
    logic       push_button;
    logic [1:0] INTx;
    logic [7:0] P0, P1;
    logic       UART_AUX_TXD, debug_led, mem_si, mem_sck, mem_hold_n, mem_cs_n;
    logic       Si3000_SDI, Si3000_SCLK, Si3000_MCLK, Si3000_RESET_N, Si3000_SDO;
    logic       SD_SPI_CS, SD_DAT2, SD_DAT1, SD_SPI_CLK, SD_SPI_DI;
    logic       I2C_SDA, I2C_SCL, PWM_OUT, JTAG_PIN6, JTAG_PIN7, JTAG_PIN8;

    mustang_fast_top_if dbg ();

    mustang_fast_top dut (
        .osc_in(clk), .push_button(push_button), .INTx(INTx),
        .P0(P0), .P1(P1), .dbg(dbg.slave),
        .UART_AUX_RXD(1'b1), .UART_AUX_TXD(UART_AUX_TXD),
        .debug_led(debug_led), .mem_so(1'b0), .mem_si(mem_si), .mem_sck(mem_sck),
        .mem_hold_n(mem_hold_n), .mem_cs_n(mem_cs_n),
        .Si3000_SDI(Si3000_SDI), .Si3000_SCLK(Si3000_SCLK), .Si3000_MCLK(Si3000_MCLK),
        .Si3000_RESET_N(Si3000_RESET_N), .Si3000_SDO(Si3000_SDO), .Si3000_FSYNC_N(1'b1),
        .SD_SPI_CS(SD_SPI_CS), .SD_DAT2(SD_DAT2), .SD_DAT1(SD_DAT1),
        .SD_SPI_CLK(SD_SPI_CLK), .SD_SPI_DI(SD_SPI_DI), .SD_SPI_DO(1'b1),
        .I2C_SDA(I2C_SDA), .I2C_SCL(I2C_SCL), .PWM_OUT(PWM_OUT),
        .JTAG_PIN6(JTAG_PIN6), .JTAG_PIN7(JTAG_PIN7), .JTAG_PIN8(JTAG_PIN8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) dbg.UART_RXD = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            dbg.UART_RXD = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        dbg.UART_RXD = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        dbg.UART_RXD = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Reply monitor: decodes each byte on UART_TXD and pops the expected value.
    initial begin
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (dbg.UART_TXD === 1'b0 && push_button === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                check("tx_start_bit", {31'b0, dbg.UART_TXD}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    rx[i] = dbg.UART_TXD;
                end
                repeat (BIT_CLKS) @(negedge clk);
                check("tx_stop_bit", {31'b0, dbg.UART_TXD}, 32'd1);
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL tx_unexpected: got %0h expected no reply", rx);
                end else begin
                    check("tx_reply", {24'b0, rx}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic       bad_first;
        logic [1:0] intx;
        logic       rd;
        logic [7:0] rd_exp;
        logic [7:0] p0, p1;
        logic       led;
        logic [2:0] jtag;
        int         pwm_hi;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int hi;
        int wait_clks;
        //            b0     b1     b2   n bad  intx  rd  rd_exp  p0     p1   led jtag  pwm
        vecs[0]  = '{8'hC0, 8'h00, 8'h5A, 3, 1'b0, 2'b00, 1'b0, 8'h00, 8'h5A, 8'hFF, 1'b0, 3'd0, -1};
        vecs[1]  = '{8'hC0, 8'h01, 8'hA5, 3, 1'b0, 2'b00, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b0, 3'd0, -1};
        vecs[2]  = '{8'hC0, 8'h02, 8'h40, 3, 1'b0, 2'b00, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b0, 3'd0, 64};
        vecs[3]  = '{8'hC0, 8'h82, 8'h00, 2, 1'b0, 2'b00, 1'b1, 8'h40, 8'h5A, 8'hA5, 1'b0, 3'd0, -1};
        vecs[4]  = '{8'hC0, 8'h02, 8'h00, 3, 1'b0, 2'b00, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b0, 3'd0, 0};
        vecs[5]  = '{8'hC0, 8'h03, 8'h01, 3, 1'b0, 2'b00, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b1, 3'd0, -1};
        vecs[6]  = '{8'hC0, 8'h83, 8'h00, 2, 1'b0, 2'b00, 1'b1, 8'h01, 8'h5A, 8'hA5, 1'b1, 3'd0, -1};
        vecs[7]  = '{8'hC0, 8'h85, 8'h00, 2, 1'b0, 2'b10, 1'b1, 8'h02, 8'h5A, 8'hA5, 1'b1, 3'd0, -1};
        vecs[8]  = '{8'hC0, 8'h86, 8'h00, 2, 1'b0, 2'b10, 1'b1, 8'h00, 8'h5A, 8'hA5, 1'b1, 3'd0, -1};
        vecs[9]  = '{8'hC1, 8'h00, 8'h33, 3, 1'b0, 2'b10, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b1, 3'd0, -1};
        vecs[10] = '{8'hC0, 8'h04, 8'h07, 3, 1'b1, 2'b10, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b1, 3'd7, -1};
        vecs[11] = '{8'hC0, 8'h05, 8'h77, 3, 1'b0, 2'b01, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b1, 3'd7, -1};
        vecs[12] = '{8'hC0, 8'h85, 8'h00, 2, 1'b0, 2'b01, 1'b1, 8'h01, 8'h5A, 8'hA5, 1'b1, 3'd7, -1};
        vecs[13] = '{8'hC0, 8'h03, 8'hFE, 3, 1'b0, 2'b01, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b0, 3'd7, -1};
        vecs[14] = '{8'hC0, 8'h83, 8'h00, 2, 1'b0, 2'b01, 1'b1, 8'h00, 8'h5A, 8'hA5, 1'b0, 3'd7, -1};
        vecs[15] = '{8'hC0, 8'h02, 8'hFF, 3, 1'b0, 2'b01, 1'b0, 8'h00, 8'h5A, 8'hA5, 1'b0, 3'd7, 255};

        dbg.UART_RXD = 1'b1;
        INTx         = 2'b00;
        push_button  = 1'b1;
        repeat (30) @(negedge clk);
        push_button = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset_state",
                  {14'b0, P0, P1, PWM_OUT, debug_led, dbg.UART_TXD, mem_cs_n, SD_SPI_CS, I2C_SDA, I2C_SCL},
                  {14'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        end
        check("reset_jtag", {29'b0, JTAG_PIN8, JTAG_PIN7, JTAG_PIN6}, 32'd0);

        for (int v = 0; v < 16; v++) begin
            INTx = vecs[v].intx;
            repeat (10) @(negedge clk);
            if (vecs[v].bad_first) send_byte(8'h55, 1'b0);
            if (vecs[v].rd) exp_q.push_back(vecs[v].rd_exp);
            send_byte(vecs[v].b0, 1'b1);
            send_byte(vecs[v].b1, 1'b1);
            if (vecs[v].n == 3) send_byte(vecs[v].b2, 1'b1);
            check($sformatf("v%0d_P0", v), {24'b0, P0}, {24'b0, vecs[v].p0});
            check($sformatf("v%0d_P1", v), {24'b0, P1}, {24'b0, vecs[v].p1});
            check($sformatf("v%0d_led", v), {31'b0, debug_led}, {31'b0, vecs[v].led});
            check($sformatf("v%0d_jtag", v), {29'b0, JTAG_PIN8, JTAG_PIN7, JTAG_PIN6},
                  {29'b0, vecs[v].jtag});
            if (vecs[v].pwm_hi >= 0) begin
                hi = 0;
                repeat (4) @(negedge clk);
                for (int c = 0; c < 256; c++) begin
                    @(negedge clk);
                    if (PWM_OUT === 1'b1) hi++;
                end
                check($sformatf("v%0d_pwm_high", v), hi, vecs[v].pwm_hi);
            end
            wait_clks = 0;
            while (exp_q.size() != 0 && wait_clks < 2000) begin
                @(negedge clk);
                wait_clks++;
            end
            if (exp_q.size() != 0) begin
                errors++;
                checks++;
                $display("FAIL v%0d_reply_timeout: got no reply expected %0h", v, exp_q.pop_front());
            end
            repeat (BIT_CLKS * 2) @(negedge clk);
        end

        // Reset in the middle of a write frame: later 00,12 must not write anything.
        send_byte(8'hC0, 1'b1);
        @(negedge clk) dbg.UART_RXD = 1'b0;
        repeat (BIT_CLKS * 3) @(negedge clk);
        push_button = 1'b1;
        dbg.UART_RXD = 1'b1;
        repeat (5) @(negedge clk);
        push_button = 1'b0;
        repeat (BIT_CLKS * 2) @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (10) @(negedge clk);
        check("midframe_reset_P0", {24'b0, P0}, 32'hFF);
        check("midframe_reset_P1", {24'b0, P1}, 32'hFF);
        check("midframe_reset_led_jtag", {28'b0, debug_led, JTAG_PIN8, JTAG_PIN7, JTAG_PIN6}, 32'd0);
        check("midframe_reset_pwm", {31'b0, PWM_OUT}, 32'd0);
        check("midframe_reset_txd", {31'b0, dbg.UART_TXD}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end
endmodule
